odometer_display: RTL and testbench
===================================

Name: odometer_display

Overview:
- Downstream consumer of the device top's `moving_state` and `power` outputs.
- Accumulates travelled distance as a 6-digit BCD odometer while the car moves forward or backward.
- Drives the 8-digit, two-bus scanned seven-segment display (`seg1`/`seg2`/`an`) with the odometer and the current global mode.
- Replaces ad-hoc segment logic in the mode blocks with one owned display stage.

Parameters:
- UNIT_CYCLES, 10_000_000, sys_clk cycles of continuous motion per odometer increment (0.1 distance unit).
- SCAN_CYCLES, 100_000, sys_clk cycles each scan position is held.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-low reset (0 = reset).
- power  input  1  engine power; 1 = powered.
- global_state  input  2  mode code 0..3, shown on digit 7.
- moving_state  input  4  [0] forward, [1] backward, [2] turn left, [3] turn right.
- clear  input  1  synchronous odometer clear, level-sensitive.
- mileage  output  24  odometer BCD, digit5..digit0 = [23:20]..[3:0], registered.
- seg1  output  8  segments for an[3:0]; bit7..0 = a,b,c,d,e,f,g,dp; active high.
- seg2  output  8  segments for an[7:4]; same encoding.
- an  output  8  digit enables, active high; an[0] is the rightmost digit.

Behaviour:
- Reset (rst=0, async): mileage=0, sub-tick counter=0, scan counter=0, scan index=0, seg1=seg2=an=0.
- Motion condition: `moving = power & (moving_state[0] ^ moving_state[1])`. Turn bits are ignored.
- Sub-tick counter:
  - Counts while moving.
  - Holds its value when not moving; a partial count is kept across pauses.
  - On reaching UNIT_CYCLES-1 while moving: wraps to 0 and mileage increments on that same edge.
- BCD increment: ripple carry per digit, each digit 0..9; 999999 -> 000000 (wrap, no flag). The increment is a single-cycle update.
- clear=1: mileage=0 and sub-tick=0 on the next edge. Clear has priority over a simultaneous increment. It works regardless of power.
- Scan counter:
  - Counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, the scan index advances 0->1->2->3->0.
- Display mapping at scan index k (one-hot sel = 1<<k):
  - an = {sel, sel}.
  - seg1 shows digit k; seg2 shows digit k+4.
  - Digits 0..5 = mileage BCD.
  - Digit 6 = blank (seg=0).
  - Digit 7 = global_state rendered as hex 0..3.
  - Decimal point lit only on digit 1.
- Output timing:
  - seg1/seg2/an are registered and reflect the index/data of the previous cycle (1-cycle latency).
  - A mileage change appears on the display at the next visit of that digit's scan position.
- Power off:
  - Odometer and sub-tick hold.
  - Scan counter and index are forced to 0.
  - an, seg1 and seg2 are forced to 0 from the next edge.
  - On power return, scanning restarts at index 0.
- Invalid digit value (not reachable): blank.
- Reset mid-operation: all state returns to reset values immediately; no partial increment is retained.

Decomposition:
- Shared package `display_pkg`:
  - 7-seg encode constants for 0-9 and A-F plus SEG_BLANK.
  - Bit-index constants MV_FWD=0, MV_BACK=1, MV_LEFT=2, MV_RIGHT=3 (to be reused by the manual/semiauto blocks).
- One sub-module, `seg7_decode`: combinational 4-bit value plus dp/blank inputs -> 8-bit segment pattern. Instantiated twice, once per bus.

Test Plan (UNIT_CYCLES=4, SCAN_CYCLES=2):
- Reset/idle: rst low 3 cycles then high, power=0 -> mileage=0, an=0, seg1=seg2=0 throughout.
- Forward count: power=1, moving_state=4'b0001 for 40 cycles -> mileage=24'h000010. an cycles 8'h11,8'h22,8'h44,8'h88, each held 2 cycles. The digit-1 position shows seg1 = "1" pattern with dp set.
- Pause and xor:
  - Move 6 cycles, idle (moving_state=0) 10 cycles, move 2 cycles -> mileage=2 (partial count retained).
  - moving_state=4'b0011 for 20 cycles -> no change.
- Wrap: preload by running to 999999 (or force-load in bench), one more unit -> mileage=000000, no other side effect.
- Clear priority: assert clear on the exact cycle an increment is due -> mileage=0, sub-tick=0 the next cycle.
- Power drop mid-scan at index 2 -> an=0 next cycle, mileage frozen. Power back with global_state=2'b10 -> first an=8'h11, and the digit-7 slot shows seg2 = "2" pattern.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants: seven-segment patterns (a..g,dp on bits 7..0), motion bit indices,
// and the BCD odometer increment helper.
package display_pkg;

   localparam int unsigned MV_FWD   = 0;
   localparam int unsigned MV_BACK  = 1;
   localparam int unsigned MV_LEFT  = 2;
   localparam int unsigned MV_RIGHT = 3;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned ODO_DIGITS = 6;
   localparam int unsigned ODO_W     = DIGIT_W * ODO_DIGITS;
   localparam int unsigned SEG_W     = 8;

   localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
   localparam logic [SEG_W-1:0] SEG_0 = 8'hFC;
   localparam logic [SEG_W-1:0] SEG_1 = 8'h60;
   localparam logic [SEG_W-1:0] SEG_2 = 8'hDA;
   localparam logic [SEG_W-1:0] SEG_3 = 8'hF2;
   localparam logic [SEG_W-1:0] SEG_4 = 8'h66;
   localparam logic [SEG_W-1:0] SEG_5 = 8'hB6;
   localparam logic [SEG_W-1:0] SEG_6 = 8'hBE;
   localparam logic [SEG_W-1:0] SEG_7 = 8'hE0;
   localparam logic [SEG_W-1:0] SEG_8 = 8'hFE;
   localparam logic [SEG_W-1:0] SEG_9 = 8'hF6;
   localparam logic [SEG_W-1:0] SEG_A = 8'hEE;
   localparam logic [SEG_W-1:0] SEG_B = 8'h3E;
   localparam logic [SEG_W-1:0] SEG_C = 8'h9C;
   localparam logic [SEG_W-1:0] SEG_D = 8'h7A;
   localparam logic [SEG_W-1:0] SEG_E = 8'h9E;
   localparam logic [SEG_W-1:0] SEG_F = 8'h8E;

   // Ripple-carry BCD +1; 999999 wraps to 000000.
   function automatic logic [ODO_W-1:0] bcd_inc(input logic [ODO_W-1:0] v);
      logic [ODO_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < int'(ODO_DIGITS); i++) begin
         if (carry) begin
            if (v[DIGIT_W*i +: DIGIT_W] == 4'd9) begin
               r[DIGIT_W*i +: DIGIT_W] = 4'd0;
            end else begin
               r[DIGIT_W*i +: DIGIT_W] = v[DIGIT_W*i +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder with decimal point and blanking.
module seg7_decode
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_value,
   input  logic               i_dp,
   input  logic               i_blank,
   output logic [SEG_W-1:0]   o_seg_c
);

   always_comb begin
      o_seg_c = SEG_BLANK;
      if (!i_blank) begin
         case (i_value)
            4'h0: o_seg_c = SEG_0;
            4'h1: o_seg_c = SEG_1;
            4'h2: o_seg_c = SEG_2;
            4'h3: o_seg_c = SEG_3;
            4'h4: o_seg_c = SEG_4;
            4'h5: o_seg_c = SEG_5;
            4'h6: o_seg_c = SEG_6;
            4'h7: o_seg_c = SEG_7;
            4'h8: o_seg_c = SEG_8;
            4'h9: o_seg_c = SEG_9;
            4'hA: o_seg_c = SEG_A;
            4'hB: o_seg_c = SEG_B;
            4'hC: o_seg_c = SEG_C;
            4'hD: o_seg_c = SEG_D;
            4'hE: o_seg_c = SEG_E;
            4'hF: o_seg_c = SEG_F;
         endcase
         o_seg_c[0] = i_dp;
      end
   end

endmodule

// File: rtl/odometer_display.sv
// Six-digit BCD odometer driven by vehicle motion, shown with the global mode on an
// eight-digit, two-bus scanned seven-segment display.
module odometer_display
   import display_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 10_000_000,
   parameter int unsigned SCAN_CYCLES = 100_000
)
(
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              power,
   input  logic [1:0]        global_state,
   input  logic [3:0]        moving_state,
   input  logic              clear,
   output logic [ODO_W-1:0]  mileage,
   output logic [SEG_W-1:0]  seg1,
   output logic [SEG_W-1:0]  seg2,
   output logic [7:0]        an
);

   localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

   logic [UW-1:0]      r_sub;
   logic [SW-1:0]      r_scan_cnt;
   logic [1:0]         r_scan_idx;
   logic [ODO_W-1:0]   r_mileage;
   logic [SEG_W-1:0]   r_seg1;
   logic [SEG_W-1:0]   r_seg2;
   logic [7:0]         r_an;

   logic               w_moving;
   logic               w_turn_unused;
   logic [UW-1:0]      w_sub_nxt;
   logic [ODO_W-1:0]   w_mileage_nxt;
   logic [SW-1:0]      w_scan_cnt_nxt;
   logic [1:0]         w_scan_idx_nxt;
   logic [3:0]         w_sel;
   logic [DIGIT_W-1:0] w_val1;
   logic [DIGIT_W-1:0] w_val2;
   logic               w_blank1;
   logic               w_blank2;
   logic               w_dp1;
   logic [SEG_W-1:0]   w_seg1_c;
   logic [SEG_W-1:0]   w_seg2_c;

   // Opposing forward/backward requests cancel; turn requests never accumulate distance.
   assign w_moving      = power & (moving_state[MV_FWD] ^ moving_state[MV_BACK]);
   assign w_turn_unused = ^moving_state[MV_RIGHT:MV_LEFT];

   // Next-state for odometer, sub-tick and scan position.
   always_comb begin
      w_sub_nxt      = r_sub;
      w_mileage_nxt  = r_mileage;
      w_scan_cnt_nxt = '0;
      w_scan_idx_nxt = '0;
      if (clear) begin
         w_sub_nxt     = '0;
         w_mileage_nxt = '0;
      end else if (w_moving) begin
         if (r_sub == UNIT_LAST) begin
            w_sub_nxt     = '0;
            w_mileage_nxt = bcd_inc(r_mileage);
         end else begin
            w_sub_nxt = r_sub + UW'(1);
         end
      end
      if (power) begin
         if (r_scan_cnt == SCAN_LAST) begin
            w_scan_cnt_nxt = '0;
            w_scan_idx_nxt = r_scan_idx + 2'd1;
         end else begin
            w_scan_cnt_nxt = r_scan_cnt + SW'(1);
            w_scan_idx_nxt = r_scan_idx;
         end
      end
   end

   // Digit selection: bus 1 carries digits 0..3, bus 2 carries digits 4..7.
   always_comb begin
      w_val1   = r_mileage[3:0];
      w_val2   = '0;
      w_blank2 = 1'b1;
      case (r_scan_idx)
         2'd0: begin
            w_val1   = r_mileage[3:0];
            w_val2   = r_mileage[19:16];
            w_blank2 = (r_mileage[19:16] > 4'd9);
         end
         2'd1: begin
            w_val1   = r_mileage[7:4];
            w_val2   = r_mileage[23:20];
            w_blank2 = (r_mileage[23:20] > 4'd9);
         end
         2'd2: begin
            w_val1   = r_mileage[11:8];
            w_val2   = '0;
            w_blank2 = 1'b1;
         end
         default: begin
            w_val1   = r_mileage[15:12];
            w_val2   = {2'b00, global_state};
            w_blank2 = 1'b0;
         end
      endcase
   end

   assign w_blank1 = (w_val1 > 4'd9);
   assign w_dp1    = (r_scan_idx == 2'd1);
   assign w_sel    = 4'b0001 << r_scan_idx;

   seg7_decode u_dec1 (
      .i_value (w_val1),
      .i_dp    (w_dp1),
      .i_blank (w_blank1),
      .o_seg_c (w_seg1_c)
   );

   seg7_decode u_dec2 (
      .i_value (w_val2),
      .i_dp    (1'b0),
      .i_blank (w_blank2),
      .o_seg_c (w_seg2_c)
   );

   // State and registered display outputs; display is dark while unpowered.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         r_sub      <= '0;
         r_mileage  <= '0;
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
         r_seg1     <= '0;
         r_seg2     <= '0;
         r_an       <= '0;
      end else begin
         r_sub      <= w_sub_nxt;
         r_mileage  <= w_mileage_nxt;
         r_scan_cnt <= w_scan_cnt_nxt;
         r_scan_idx <= w_scan_idx_nxt;
         if (power) begin
            r_an   <= {w_sel, w_sel};
            r_seg1 <= w_seg1_c;
            r_seg2 <= w_seg2_c;
         end else begin
            r_an   <= '0;
            r_seg1 <= '0;
            r_seg2 <= '0;
         end
      end
   end

   assign mileage = r_mileage;
   assign seg1    = r_seg1;
   assign seg2    = r_seg2;
   assign an      = r_an;

endmodule

// File: tb/tb_odometer_display.sv
// Self-checking bench for odometer_display: directed scenarios plus randomized traffic
// compared against a decimal-arithmetic reference model.
module tb_odometer_display;

   localparam int UNIT = 4;
   localparam int SCAN = 2;

   localparam logic [7:0] SEG_TAB [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E };

   logic        sys_clk = 1'b0;
   logic        rst = 1'b0;
   logic        power = 1'b0;
   logic [1:0]  global_state = 2'b00;
   logic [3:0]  moving_state = 4'b0000;
   logic        clear = 1'b0;
   logic [23:0] mileage;
   logic [7:0]  seg1;
   logic [7:0]  seg2;
   logic [7:0]  an;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: distance in tenths, motion cycles since last unit, cycles since power-on.
   int m_miles = 0;
   int m_sub   = 0;
   int m_scan  = 0;
   logic [7:0] e_an, e_s1, e_s2;

   odometer_display #(.UNIT_CYCLES(UNIT), .SCAN_CYCLES(SCAN)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .power        (power),
      .global_state (global_state),
      .moving_state (moving_state),
      .clear        (clear),
      .mileage      (mileage),
      .seg1         (seg1),
      .seg2         (seg2),
      .an           (an)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int digit_of(input int v, input int k);
      int x;
      x = v;
      for (int i = 0; i < k; i++) x = x / 10;
      return x % 10;
   endfunction

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // One clock: drive at negedge, predict from pre-edge model state, check after posedge.
   task automatic cycle(input logic p, input logic [3:0] ms, input logic [1:0] gs, input logic clr);
      int k;
      logic [3:0] sel;
      logic mv;
      @(negedge sys_clk);
      power = p; moving_state = ms; global_state = gs; clear = clr;
      mv = p && (ms[0] != ms[1]);
      if (p) begin
         k    = (m_scan / SCAN) % 4;
         sel  = 4'(1 << k);
         e_an = {sel, sel};
         e_s1 = SEG_TAB[digit_of(m_miles, k)] | ((k == 1) ? 8'h01 : 8'h00);
         case (k)
            0:       e_s2 = SEG_TAB[digit_of(m_miles, 4)];
            1:       e_s2 = SEG_TAB[digit_of(m_miles, 5)];
            2:       e_s2 = 8'h00;
            default: e_s2 = SEG_TAB[int'(gs)];
         endcase
         m_scan++;
      end else begin
         e_an = 8'h00; e_s1 = 8'h00; e_s2 = 8'h00;
         m_scan = 0;
      end
      if (clr) begin
         m_miles = 0;
         m_sub   = 0;
      end else if (mv) begin
         m_sub++;
         if (m_sub == UNIT) begin
            m_sub   = 0;
            m_miles = (m_miles + 1) % 1000000;
         end
      end
      @(posedge sys_clk);
      #1;
      check("mileage", 32'(mileage), 32'(to_bcd(m_miles)));
      check("an",      32'(an),      32'(e_an));
      check("seg1",    32'(seg1),    32'(e_s1));
      check("seg2",    32'(seg2),    32'(e_s2));
   endtask

   task automatic model_reset();
      m_miles = 0; m_sub = 0; m_scan = 0;
   endtask

   initial begin
      int saved;
      // Reset with power off
      rst = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_mileage", 32'(mileage), 32'h0);
      check("rst_an",      32'(an),      32'h0);
      check("rst_seg1",    32'(seg1),    32'h0);
      check("rst_seg2",    32'(seg2),    32'h0);
      rst = 1'b1;
      model_reset();
      repeat (5) cycle(1'b0, 4'b0000, 2'b01, 1'b0);

      // Forward count
      repeat (40) cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      check("fwd40_mileage", 32'(mileage), 32'h10);
      repeat (4) cycle(1'b1, 4'b0000, 2'b00, 1'b0);
      check("digit1_an",   32'(an),   32'h22);
      check("digit1_seg1", 32'(seg1), 32'h61);

      // Pause keeps partial count; opposing directions do not count
      cycle(1'b1, 4'b0000, 2'b00, 1'b1);
      repeat (6)  cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      repeat (10) cycle(1'b1, 4'b0000, 2'b00, 1'b0);
      repeat (2)  cycle(1'b1, 4'b0010, 2'b00, 1'b0);
      check("pause_mileage", 32'(mileage), 32'h2);
      repeat (20) cycle(1'b1, 4'b0011, 2'b00, 1'b0);
      check("xor_mileage", 32'(mileage), 32'h2);
      repeat (8) cycle(1'b1, 4'b1100, 2'b00, 1'b0);
      check("turn_mileage", 32'(mileage), 32'h2);

      // Clear on the increment cycle wins and resets the sub-tick
      repeat (3) cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      cycle(1'b1, 4'b0001, 2'b00, 1'b1);
      check("clr_prio", 32'(mileage), 32'h0);
      repeat (3) cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      check("clr_sub_zero", 32'(mileage), 32'h0);
      cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      check("clr_then_unit", 32'(mileage), 32'h1);

      // Wrap 999999 -> 000000
      cycle(1'b1, 4'b0000, 2'b00, 1'b1);
      force dut.r_mileage = 24'h999999;
      #1;
      release dut.r_mileage;
      m_miles = 999999;
      repeat (3) cycle(1'b1, 4'b0001, 2'b11, 1'b0);
      check("pre_wrap", 32'(mileage), 32'h999999);
      cycle(1'b1, 4'b0001, 2'b11, 1'b0);
      check("wrap", 32'(mileage), 32'h0);
      repeat (9) cycle(1'b1, 4'b0010, 2'b11, 1'b0);

      // Power drop at scan index 2, then recover with mode 2
      cycle(1'b0, 4'b0000, 2'b00, 1'b0);
      repeat (4) cycle(1'b1, 4'b0000, 2'b00, 1'b0);
      cycle(1'b1, 4'b0001, 2'b00, 1'b0);
      check("idx2_an", 32'(an), 32'h44);
      saved = m_miles;
      cycle(1'b0, 4'b0001, 2'b00, 1'b0);
      check("pwroff_an",   32'(an),   32'h0);
      check("pwroff_seg1", 32'(seg1), 32'h0);
      repeat (9) cycle(1'b0, 4'b0001, 2'b00, 1'b0);
      check("pwroff_frozen", 32'(mileage), 32'(to_bcd(saved)));
      cycle(1'b1, 4'b0000, 2'b10, 1'b0);
      check("pwron_an", 32'(an), 32'h11);
      repeat (6) cycle(1'b1, 4'b0000, 2'b10, 1'b0);
      check("mode_an",   32'(an),   32'h88);
      check("mode_seg2", 32'(seg2), 32'hDA);

      // Randomized traffic with one asynchronous reset mid-run
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            @(negedge sys_clk);
            #2 rst = 1'b0;
            #1;
            check("async_rst_mileage", 32'(mileage), 32'h0);
            check("async_rst_an",      32'(an),      32'h0);
            check("async_rst_seg1",    32'(seg1),    32'h0);
            model_reset();
            @(posedge sys_clk);
            #1 rst = 1'b1;
         end
         cycle(1'($urandom_range(0, 9) != 0), 4'($urandom), 2'($urandom),
               1'($urandom_range(0, 59) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
